gray_step_monitor: RTL

Downstream consumer of the binary-to-Gray stage. Accepts a stream of Gray-coded words with a valid strobe, decodes each word back to binary, classifies every transition against the previous word as up-step, down-step, hold or illegal jump, and raises a sticky fault after a run of illegal jumps. All outputs are registered; the block feeds status and decoded position to control logic.

---
 rtl/gray_pkg.sv | 13 +
 rtl/gray_binary.sv | 14 +
 rtl/gray_step_monitor.sv | 110 +++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code pipeline: default word width and
// the step-monitor state encoding.
package gray_pkg;

  localparam int GRAY_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

endpackage : gray_pkg

// File: rtl/gray_binary.sv
// Purely combinational Gray-to-binary decoder.
// Each binary bit is the XOR of every Gray bit at or above its position.
module gray_binary #(
  parameter int W = 3
) (
  input  logic [W-1:0] g,
  output logic [W-1:0] b
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign b[i] = ^g[W-1:i];
  end

endmodule : gray_binary

// File: rtl/gray_step_monitor.sv
// Decodes a Gray-coded sample stream, classifies each transition as
// up/down/hold/illegal, counts illegal jumps and latches a sticky fault.
module gray_step_monitor
  import gray_pkg::*;
#(
  parameter int W         = GRAY_W,
  parameter int ERR_LIMIT = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [W-1:0]     g_in,
  input  logic             clr,
  output logic             out_valid,
  output logic [W-1:0]     b_out,
  output logic             dir_up,
  output logic             dir_dn,
  output logic             step_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fault
);

  localparam int CW = $clog2(ERR_LIMIT + 1);

  state_t           state_q, state_d;
  logic [W-1:0]     b_new, prev_q, prev_inc, prev_dec;
  logic [CW-1:0]    consec_q, consec_d;
  logic [CNT_W-1:0] err_cnt_d;
  logic             accept, tracking, is_up, is_dn, is_hold, track_err;
  logic             out_valid_d, dir_up_d, dir_dn_d, step_err_d;

  gray_binary #(.W(W)) u_decode (
    .g (g_in),
    .b (b_new)
  );

  // clr wins over a simultaneous sample, so the sample is never accepted
  assign accept    = in_valid & ~clr;
  assign tracking  = accept & (state_q == TRACK);
  assign prev_inc  = prev_q + 1'b1;
  assign prev_dec  = prev_q - 1'b1;
  assign is_up     = (b_new == prev_inc);
  assign is_dn     = (b_new == prev_dec);
  assign is_hold   = (b_new == prev_q);
  assign track_err = tracking & ~(is_up | is_dn | is_hold);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (in_valid) state_d = TRACK;
        TRACK:   if (track_err && consec_q == CW'(ERR_LIMIT - 1)) state_d = FAULT;
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    out_valid_d = accept;
    dir_up_d    = tracking & is_up;
    dir_dn_d    = tracking & is_dn;
    step_err_d  = track_err;

    consec_d = consec_q;
    if (clr)                           consec_d = '0;
    else if (tracking & (is_up|is_dn)) consec_d = '0;
    else if (track_err)                consec_d = consec_q + 1'b1;

    err_cnt_d = err_cnt;
    if (clr)                                        err_cnt_d = '0;
    else if (track_err && err_cnt != {CNT_W{1'b1}}) err_cnt_d = err_cnt + 1'b1;
  end

  // prev resyncs on every accepted sample, legal or not
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '0;
      consec_q  <= '0;
      out_valid <= 1'b0;
      b_out     <= '0;
      dir_up    <= 1'b0;
      dir_dn    <= 1'b0;
      step_err  <= 1'b0;
      err_cnt   <= '0;
      fault     <= 1'b0;
    end else begin
      if (accept) begin
        prev_q <= b_new;
        b_out  <= b_new;
      end
      consec_q  <= consec_d;
      out_valid <= out_valid_d;
      dir_up    <= dir_up_d;
      dir_dn    <= dir_dn_d;
      step_err  <= step_err_d;
      err_cnt   <= err_cnt_d;
      fault     <= (state_d == FAULT);
    end
  end

endmodule : gray_step_monitor
